fft_peak_topk: RTL and testbench

//  Streaming top-K spectral peak finder; successor to the single-peak finder behind fft_mag_sq.

---
 rtl/fft_peak_topk_if.sv | 27 ++
 rtl/fft_peak_topk.sv | 207 ++++++++++++++++++++
 tb/tb_fft_peak_topk.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fft_peak_topk_if.sv
// rtl/fft_peak_topk_if.sv - bin input and ranked-peak output bundle for fft_peak_topk
interface fft_peak_topk_if #(
  parameter int W        = 33,
  parameter int NSamples = 1024,
  parameter int K        = 4
);
  logic [W-1:0]                mag;
  logic                        mag_valid;
  logic [W-1:0]                threshold;
  logic [W-1:0]                peak_mag;
  logic [$clog2(NSamples)-1:0] peak_k;
  logic [$clog2(K):0]          peak_rank;
  logic                        peak_last;
  logic                        peak_valid;
  logic                        peak_ready;
  logic                        frame_overrun;

  modport master (
    output mag, mag_valid, threshold, peak_ready,
    input  peak_mag, peak_k, peak_rank, peak_last, peak_valid, frame_overrun
  );

  modport slave (
    input  mag, mag_valid, threshold, peak_ready,
    output peak_mag, peak_k, peak_rank, peak_last, peak_valid, frame_overrun
  );
endinterface

// File: rtl/fft_peak_topk.sv
// rtl/fft_peak_topk.sv - streaming top-K spectral peak finder (FFT_PEAK_LOCAL_MAX_EN adds local-max gating)
module fft_peak_topk #(
  parameter int W        = 33,
  parameter int NSamples = 1024,
  parameter int K        = 4,
  parameter int MIN_BIN  = 1,
  parameter int MAX_BIN  = 511
) (
  input logic           clk,
  input logic           reset,
  fft_peak_topk_if.slave bus
);
  localparam int BW = $clog2(NSamples);
  localparam int KW = $clog2(K) + 1;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [BW-1:0] LAST_BIN = BW'(NSamples - 1);

  typedef enum logic {IDLE, EMIT} state_t;
  state_t state, state_n;

  logic [BW-1:0] bin_cnt;
  logic [W-1:0]  list_mag [K];
  logic [BW-1:0] list_k   [K];
  logic [KW-1:0] list_fill;
  logic [W-1:0]  snap_mag [K];
  logic [BW-1:0] snap_k   [K];
  logic [KW-1:0] snap_fill;
  logic          frame_end_d;
  logic          overrun;
  logic [IW-1:0] idx, idx_n;

  logic          cand_ok, cand_last;
  logic [W-1:0]  cand_mag;
  logic [BW-1:0] cand_k;

  logic [W-1:0]  b_mag [K];
  logic [BW-1:0] b_k   [K];
  logic [W-1:0]  n_mag [K];
  logic [BW-1:0] n_k   [K];
  logic [KW-1:0] b_fill, n_fill, pos, n_beats;
  logic          found, ins;
  logic          load, drop, hs, last_hs, is_last;

`ifdef FFT_PEAK_LOCAL_MAX_EN
  logic          p_valid, p_eval;
  logic [W-1:0]  p_mag, p_left, p_thr, p_right;
  logic [BW-1:0] p_k;

  // Judge the pending bin once its right neighbour arrives, or in the flush cycle for the last bin
  always_comb begin
    p_eval    = p_valid && (bus.mag_valid || p_k == LAST_BIN);
    p_right   = (p_k == LAST_BIN) ? '0 : bus.mag;
    cand_mag  = p_mag;
    cand_k    = p_k;
    cand_last = p_eval && (p_k == LAST_BIN);
    cand_ok   = p_eval && (p_k >= BW'(MIN_BIN)) && (p_k <= BW'(MAX_BIN)) &&
                (p_mag > p_thr) && (p_mag > p_left) && (p_mag >= p_right);
  end

  // One-bin delay line holding the bin under test, its threshold and its left neighbour
  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_mag   <= '0;
      p_left  <= '0;
      p_thr   <= '0;
      p_k     <= '0;
    end else if (bus.mag_valid) begin
      p_valid <= 1'b1;
      p_mag   <= bus.mag;
      p_thr   <= bus.threshold;
      p_k     <= bin_cnt;
      p_left  <= (bin_cnt == '0) ? '0 : p_mag;
    end else if (p_eval) begin
      p_valid <= 1'b0;
    end
  end
`else
  // Without the local-max rule the incoming beat itself is the candidate
  always_comb begin
    cand_mag  = bus.mag;
    cand_k    = bin_cnt;
    cand_last = bus.mag_valid && (bin_cnt == LAST_BIN);
    cand_ok   = bus.mag_valid && (bin_cnt >= BW'(MIN_BIN)) && (bin_cnt <= BW'(MAX_BIN)) &&
                (bus.mag > bus.threshold);
  end
`endif

  // Sorted insert into the collect list; a frame-end cycle inserts into an already-cleared list
  always_comb begin
    b_fill = frame_end_d ? '0 : list_fill;
    for (int i = 0; i < K; i++) begin
      b_mag[i] = frame_end_d ? '0 : list_mag[i];
      b_k[i]   = frame_end_d ? '0 : list_k[i];
    end
    pos   = KW'(K);
    found = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (!found && ((KW'(i) >= b_fill) || (cand_mag > b_mag[i]))) begin
        pos   = KW'(i);
        found = 1'b1;
      end
    end
    ins    = cand_ok && (pos < KW'(K));
    n_fill = (ins && (b_fill < KW'(K))) ? b_fill + KW'(1) : b_fill;
    n_mag[0] = (ins && pos == '0) ? cand_mag : b_mag[0];
    n_k[0]   = (ins && pos == '0) ? cand_k   : b_k[0];
    for (int i = 1; i < K; i++) begin
      if (!ins || (KW'(i) < pos)) begin
        n_mag[i] = b_mag[i];
        n_k[i]   = b_k[i];
      end else if (KW'(i) == pos) begin
        n_mag[i] = cand_mag;
        n_k[i]   = cand_k;
      end else begin
        n_mag[i] = b_mag[i-1];
        n_k[i]   = b_k[i-1];
      end
    end
  end

  // Emission control: snapshot load/drop decision, beat advance and IDLE/EMIT transitions
  always_comb begin
    state_n = state;
    idx_n   = idx;
    load    = 1'b0;
    drop    = 1'b0;
    n_beats = (snap_fill == '0) ? KW'(1) : snap_fill;
    is_last = (KW'(idx) == n_beats - KW'(1));
    hs      = (state == EMIT) && bus.peak_ready;
    last_hs = hs && is_last;
    if (frame_end_d) begin
      if (state == IDLE || last_hs) load = 1'b1;
      else                          drop = 1'b1;
    end
    case (state)
      IDLE: begin
        if (load) begin
          state_n = EMIT;
          idx_n   = '0;
        end
      end
      EMIT: begin
        if (load) begin
          idx_n = '0;
        end else if (last_hs) begin
          state_n = IDLE;
          idx_n   = '0;
        end else if (hs) begin
          idx_n = idx + IW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state and beat index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Bin counter, collect list, snapshot and overrun pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_cnt     <= '0;
      frame_end_d <= 1'b0;
      overrun     <= 1'b0;
      list_fill   <= '0;
      snap_fill   <= '0;
      for (int i = 0; i < K; i++) begin
        list_mag[i] <= '0;
        list_k[i]   <= '0;
        snap_mag[i] <= '0;
        snap_k[i]   <= '0;
      end
    end else begin
      if (bus.mag_valid) bin_cnt <= (bin_cnt == LAST_BIN) ? '0 : bin_cnt + BW'(1);
      frame_end_d <= cand_last;
      overrun     <= drop;
      list_fill   <= n_fill;
      for (int i = 0; i < K; i++) begin
        list_mag[i] <= n_mag[i];
        list_k[i]   <= n_k[i];
      end
      if (load) begin
        snap_fill <= list_fill;
        for (int i = 0; i < K; i++) begin
          snap_mag[i] <= list_mag[i];
          snap_k[i]   <= list_k[i];
        end
      end
    end
  end

  assign bus.peak_valid    = (state == EMIT);
  assign bus.peak_mag      = (state == EMIT) ? snap_mag[idx] : '0;
  assign bus.peak_k        = (state == EMIT) ? snap_k[idx] : '0;
  assign bus.peak_rank     = (state == EMIT) ? KW'(idx) : '0;
  assign bus.peak_last     = (state == EMIT) && is_last;
  assign bus.frame_overrun = overrun;
endmodule

// File: tb/tb_fft_peak_topk.sv
// tb/tb_fft_peak_topk.sv - directed self-checking bench for fft_peak_topk
module tb_fft_peak_topk;
  localparam int W  = 33;
  localparam int NS = 1024;
  localparam int K  = 4;
`ifdef FFT_PEAK_LOCAL_MAX_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset;

  fft_peak_topk_if #(.W(W), .NSamples(NS), .K(K)) bus ();

  fft_peak_topk #(.W(W), .NSamples(NS), .K(K), .MIN_BIN(1), .MAX_BIN(511)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;
  int lat;
  logic [W-1:0] fm [NS];
  logic [W-1:0] q_mag [$];
  int q_k [$];
  int q_rank [$];
  int q_last [$];
  logic [W-1:0] e_mag [8];
  int e_k [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic set_all(input logic [W-1:0] v);
    for (int i = 0; i < NS; i++) fm[i] = v;
  endtask

  task automatic run_frame(input logic [W-1:0] thr);
    bus.threshold = thr;
    for (int i = 0; i < NS; i++) begin
      bus.mag       = fm[i];
      bus.mag_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.mag_valid = 1'b0;
    bus.mag       = '0;
  endtask

  task automatic collect();
    int n;
    q_mag.delete(); q_k.delete(); q_rank.delete(); q_last.delete();
    lat = 0;
    while (!bus.peak_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n = 0;
    while (bus.peak_valid && n < K + 2) begin
      q_mag.push_back(bus.peak_mag);
      q_k.push_back(int'(bus.peak_k));
      q_rank.push_back(int'(bus.peak_rank));
      q_last.push_back(int'(bus.peak_last));
      n++;
      if (bus.peak_last) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic verify(input string name, input int n);
    check({name, "_latency"}, lat, LAT - 1);
    check({name, "_beats"}, q_k.size(), n);
    for (int i = 0; i < n && i < q_k.size(); i++) begin
      check($sformatf("%s_k%0d", name, i), q_k[i], e_k[i]);
      check($sformatf("%s_mag%0d", name, i), q_mag[i], e_mag[i]);
      check($sformatf("%s_rank%0d", name, i), q_rank[i], i);
      check($sformatf("%s_last%0d", name, i), q_last[i], (i == n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int ov;
    int kchg;
    reset = 1'b1;
    bus.mag = '0;
    bus.mag_valid = 1'b0;
    bus.threshold = '0;
    bus.peak_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.peak_valid, 0);
    check("rst_mag", bus.peak_mag, 0);
    check("rst_k", bus.peak_k, 0);
    check("rst_last", bus.peak_last, 0);
    check("rst_overrun", bus.frame_overrun, 0);
    reset = 1'b0;

    set_all(10); fm[37] = 5000;
    run_frame(100); collect();
    e_k[0] = 37; e_mag[0] = 5000;
    verify("tone", 1);

    set_all(0);
    fm[10] = 100; fm[20] = 500; fm[30] = 300; fm[40] = 900; fm[50] = 200;
    run_frame(0); collect();
    e_k[0] = 40; e_mag[0] = 900;
    e_k[1] = 20; e_mag[1] = 500;
    e_k[2] = 30; e_mag[2] = 300;
    e_k[3] = 50; e_mag[3] = 200;
    verify("sort", 4);

    set_all(0); fm[0] = 9999; fm[12] = 700; fm[80] = 700;
    run_frame(0); collect();
    e_k[0] = 12; e_mag[0] = 700;
    e_k[1] = 80; e_mag[1] = 700;
    verify("tie", 2);

    set_all(0); fm[511] = 300; fm[512] = 999; fm[1023] = 888;
    run_frame(0); collect();
    e_k[0] = 511; e_mag[0] = 300;
    verify("window", 1);

    set_all(50);
    run_frame(50); collect();
    e_k[0] = 0; e_mag[0] = 0;
    verify("empty", 1);

`ifdef FFT_PEAK_LOCAL_MAX_EN
    set_all(0); fm[60] = 400; fm[61] = 800; fm[62] = 600;
    run_frame(0); collect();
    e_k[0] = 61; e_mag[0] = 800;
    verify("localmax", 1);
`endif

    bus.peak_ready = 1'b0;
    set_all(10); fm[37] = 5000;
    run_frame(100);
    lat = 0;
    while (!bus.peak_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("stall_valid", bus.peak_valid, 1);
    check("stall_k", bus.peak_k, 37);
    set_all(0); fm[40] = 900; fm[20] = 500;
    ov = 0;
    kchg = 0;
    fork
      run_frame(0);
      begin
        for (int c = 0; c < NS + 20; c++) begin
          @(posedge clk); #1;
          if (bus.frame_overrun) ov++;
          if (!bus.peak_valid || bus.peak_k != 37) kchg++;
        end
      end
    join
    check("overrun_pulses", ov, 1);
    check("stall_hold", kchg, 0);
    check("stall_mag", bus.peak_mag, 5000);

    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_valid", bus.peak_valid, 0);
    check("midreset_mag", bus.peak_mag, 0);
    reset = 1'b0;
    bus.peak_ready = 1'b1;

    set_all(10); fm[300] = 4000;
    run_frame(100); collect();
    e_k[0] = 300; e_mag[0] = 4000;
    verify("recover", 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
